// File: rtl/seg_src_mux.sv
// Registered N-channel selector for seven-segment codes. Select requests are held
// pending and only applied on a frame tick; optional tick-driven blink blanking.
module seg_src_mux #(
    parameter int             W         = 7,
    parameter int             N         = 4,
    parameter int             SELW      = 2,
    parameter int             BLINK_DIV = 8,
    parameter logic [W-1:0]   BLANK     = {W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    num,
    input  logic [SELW-1:0]   sel,
    input  logic              sel_valid,
    output logic              sel_ready,
    output logic              sel_err,
    input  logic              tick,
    input  logic              blink_en,
    output logic [SELW-1:0]   active_sel,
    output logic              blink_phase,
    output logic [W-1:0]      o
);
    localparam int              CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [SELW:0]   N_EXT   = (SELW+1)'(N);

    logic [W-1:0]    chan [N];
    logic [W-1:0]    routed;
    logic            pending_reg;
    logic [SELW-1:0] pend_sel_reg;
    logic [SELW-1:0] active_sel_reg;
    logic            sel_err_reg;
    logic [CW-1:0]   cnt_reg;
    logic            blink_phase_reg;
    logic [W-1:0]    o_reg;
    logic            accept;
    logic            in_range;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        assign chan[gi] = num[gi*W +: W];
    end

    // active_sel only ever holds an in-range index, so the BLANK default is unreachable
    always_comb begin
        routed = BLANK;
        for (int i = 0; i < N; i++) begin
            if ({1'b0, active_sel_reg} == (SELW+1)'(i)) begin
                routed = chan[i];
            end
        end
    end

    assign accept   = sel_valid & ~pending_reg;
    assign in_range = ({1'b0, sel} < N_EXT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg     <= 1'b0;
            pend_sel_reg    <= '0;
            active_sel_reg  <= '0;
            sel_err_reg     <= 1'b0;
            cnt_reg         <= '0;
            blink_phase_reg <= 1'b0;
            o_reg           <= BLANK;
        end else begin
            sel_err_reg <= accept & ~in_range;

            // accept requires pending=0, so apply and accept never collide
            if (tick && pending_reg) begin
                active_sel_reg <= pend_sel_reg;
                pending_reg    <= 1'b0;
            end else if (accept && in_range) begin
                pend_sel_reg <= sel;
                pending_reg  <= 1'b1;
            end

            if (!blink_en) begin
                cnt_reg         <= '0;
                blink_phase_reg <= 1'b0;
            end else if (tick) begin
                if (cnt_reg == CNT_MAX) begin
                    cnt_reg         <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            o_reg <= (blink_en && blink_phase_reg) ? BLANK : routed;
        end
    end

    assign sel_ready   = ~pending_reg;
    assign sel_err     = sel_err_reg;
    assign active_sel  = active_sel_reg;
    assign blink_phase = blink_phase_reg;
    assign o           = o_reg;

endmodule
